// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: captures a branch request from decode, resolves it a
// cycle later, redirects fetch on a taken branch, then holds a pipeline flush
// for FLUSH_CYCLES cycles. Also keeps saturating taken/not-taken statistics.
module branch_redirect_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       opCode,
  input  logic             zero,
  input  logic [15:0]      br_pc,
  input  logic [15:0]      br_imm,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [15:0]      target_pc,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // The RESOLVE cycle already counts as one flush cycle, so FLUSH itself
  // lasts FLUSH_CYCLES-1 cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state, stateNext;
  logic [3:0]  flushCnt, flushCntNext;
  logic [15:0] pcCap, immCap;
  logic        zeroCap;
  logic [15:0] targetReg;
  logic [15:0] targetSum;
  logic        capture;
  logic        countTaken;
  logic        countNotTaken;
  logic        unusedOpBits;

  // Only the branch-class bit of the opcode matters here.
  assign unusedOpBits = ^opCode[2:0];

  // Redirect target, wrapping modulo 2^16.
  assign targetSum = pcCap + immCap;

  // Next-state and output decode.
  always_comb begin
    stateNext      = state;
    flushCntNext   = flushCnt;
    br_ready       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    target_pc      = targetReg;
    capture        = 1'b0;
    countTaken     = 1'b0;
    countNotTaken  = 1'b0;
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid && opCode[3]) begin
          capture   = 1'b1;
          stateNext = RESOLVE;
        end
      end
      RESOLVE: begin
        if (!stall) begin
          if (zeroCap) begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            target_pc      = targetSum;
            countTaken     = 1'b1;
            flushCntNext   = FLUSH_LOAD;
            stateNext      = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
          end else begin
            countNotTaken = 1'b1;
            stateNext     = IDLE;
          end
        end
      end
      FLUSH: begin
        flush        = 1'b1;
        flushCntNext = flushCnt - 4'd1;
        if (flushCnt <= 4'd1) begin
          flushCntNext = '0;
          stateNext    = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, flush counter and captured request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      flushCnt <= '0;
      pcCap    <= '0;
      immCap   <= '0;
      zeroCap  <= 1'b0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
      if (capture) begin
        pcCap   <= br_pc;
        immCap  <= br_imm;
        zeroCap <= zero;
      end
    end
  end

  // Last redirect target, held between redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      targetReg <= '0;
    end else if (redirect_valid) begin
      targetReg <= targetSum;
    end
  end

  // Saturating taken/not-taken statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else begin
      if (countTaken && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
      if (countNotTaken && (not_taken_cnt != '1)) begin
        not_taken_cnt <= not_taken_cnt + 1'b1;
      end
    end
  end

endmodule
